// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op codes, FSM states,
// and the operand-signedness helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b11000,
    OP_MULH   = 5'b11001,
    OP_MULHSU = 5'b11010,
    OP_MULHU  = 5'b11011,
    OP_DIV    = 5'b11100,
    OP_REM    = 5'b11101,
    OP_DIVU   = 5'b11110,
    OP_REMU   = 5'b11111
  } mdop_t;

  localparam logic [1:0] MDOP_CLASS = 2'b11;

  function automatic logic is_mdop(input logic [4:0] sel);
    return sel[4:3] == MDOP_CLASS;
  endfunction

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic a_is_signed(input logic [2:0] func);
    return func[2] ? !func[1] : !(func[1] & func[0]);
  endfunction

  // rs2 is signed for MUL/MULH/DIV/REM
  function automatic logic b_is_signed(input logic [2:0] func);
    return !func[1];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [4:0]       select;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, select, data1, data2, flush,
                  input  busy, done, result);
  modport slave  (input  start, select, data1, data2, flush,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One radix-2 iteration over the {acc, op} pair: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] op_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, operand};
    rem_sh  = {acc, op[WIDTH-1]};
    diff    = rem_sh - {1'b0, operand};
    acc_nxt = acc;
    op_nxt  = op;
    if (mode_div) begin
      // partial remainder stays below the divisor, so diff's top bit is the borrow
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        op_nxt  = {op[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        op_nxt  = {op[WIDTH-2:0], 1'b0};
      end
    end else if (op[0]) begin
      {acc_nxt, op_nxt} = {sum, op[WIDTH-1:1]};
    end else begin
      {acc_nxt, op_nxt} = {1'b0, acc, op[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Define FAST_MUL_EN to route the multiply ops through a single-cycle multiplier.
//
// state | meaning
// IDLE  | waiting for START with an M-op code
// CALC  | one radix-2 step per cycle, cnt counts 0..WIDTH-1
// FIX   | sign correction / word select, RESULT registered
// DONE  | one-cycle DONE pulse; a new START is accepted here
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  mdop_t            op_q;
  logic [WIDTH-1:0] acc, opr, operand;
  logic [WIDTH-1:0] early_res, result_q;
  logic             neg_q, early_q;
  logic             accept;

  logic [2:0]       func;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             early_hit;
  logic [WIDTH-1:0] early_val;
  logic [WIDTH-1:0] acc_nxt, opr_nxt;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign func = bus.select[2:0];

  always_comb begin
    a_neg = a_is_signed(func) & bus.data1[WIDTH-1];
    b_neg = b_is_signed(func) & bus.data2[WIDTH-1];
    a_mag = a_neg ? -bus.data1 : bus.data1;
    b_mag = b_neg ? -bus.data2 : bus.data2;
  end

`ifdef FAST_MUL_EN
  logic [2*WIDTH+1:0] fast_a, fast_b, fast_p;
  assign fast_a = {{(WIDTH+2){a_is_signed(func) & bus.data1[WIDTH-1]}}, bus.data1};
  assign fast_b = {{(WIDTH+2){b_is_signed(func) & bus.data2[WIDTH-1]}}, bus.data2};
  assign fast_p = fast_a * fast_b;
`endif

  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (func[2]) begin
      if (bus.data2 == '0) begin
        early_hit = 1'b1;
        early_val = func[0] ? bus.data1 : '1;
      end else if (!func[1] && bus.data1 == MIN_NEG && bus.data2 == '1) begin
        // signed overflow: quotient wraps to MIN, remainder is zero
        early_hit = 1'b1;
        early_val = func[0] ? '0 : MIN_NEG;
      end
    end
`ifdef FAST_MUL_EN
    else begin
      early_hit = 1'b1;
      early_val = (func[1:0] == 2'b00) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start && is_mdop(bus.select)) begin
            accept    = 1'b1;
            state_nxt = early_hit ? ST_FIX : ST_CALC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (op_q[2]),
    .acc      (acc),
    .op       (opr),
    .operand  (operand),
    .acc_nxt  (acc_nxt),
    .op_nxt   (opr_nxt)
  );

  always_comb begin
    prod     = {acc, opr};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -opr : opr;
    rem_fix  = neg_q ? -acc : acc;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
    if (early_q) fix_res = early_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      op_q      <= OP_MUL;
      acc       <= '0;
      opr       <= '0;
      operand   <= '0;
      neg_q     <= 1'b0;
      early_q   <= 1'b0;
      early_res <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt       <= '0;
      op_q      <= mdop_t'(bus.select);
      acc       <= '0;
      // multiply shifts the multiplier through opr; divide shifts the dividend
      opr       <= func[2] ? a_mag : b_mag;
      operand   <= func[2] ? b_mag : a_mag;
      neg_q     <= (func[2] && func[0]) ? a_neg : (a_neg ^ b_neg);
      early_q   <= early_hit;
      early_res <= early_val;
    end else if (!bus.flush) begin
      if (state == ST_CALC) begin
        acc <= acc_nxt;
        opr <= opr_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_FIX) result_q <= fix_res;
    end
  end

  assign bus.busy   = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (honours FAST_MUL_EN for multiply latency).
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT   = 33;
  localparam int EARLY_LAT = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // edges after the START edge until DONE, plus cycles BUSY was seen high
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] exp, input int exp_lat);
    int lat, bcnt;
    @(negedge clk);
    bus.start = 1'b1; bus.select = sel; bus.data1 = d1; bus.data2 = d2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int lat, bcnt, seen;
    reset = 1'b1;
    bus.start = 1'b0; bus.select = '0; bus.data1 = '0; bus.data2 = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", bus.result, 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("mul_5x2",     5'b11000, 32'd5,          32'd2,          32'd10,         MUL_LAT);
    run_op("mul_big",     5'b11000, 32'h1234_5678,  32'd9,          32'hA3D7_0A38,  MUL_LAT);
    run_op("mul_m1m1",    5'b11000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          MUL_LAT);
    run_op("mulh_m1m1",   5'b11001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          MUL_LAT);
    run_op("mulhu_max",   5'b11011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT);
    run_op("mulhsu_m1x2", 5'b11010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT);
    run_op("div_m7_2",    5'b11100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DIV_LAT);
    run_op("rem_m7_2",    5'b11101, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DIV_LAT);
    run_op("div_7_m2",    5'b11100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  DIV_LAT);
    run_op("rem_7_m2",    5'b11101, 32'd7,          32'hFFFF_FFFE,  32'd1,          DIV_LAT);
    run_op("remu_27_5",   5'b11111, 32'd27,         32'd5,          32'd2,          DIV_LAT);
    run_op("divu_100_7",  5'b11110, 32'd100,        32'd7,          32'd14,         DIV_LAT);
    run_op("divu_by0",    5'b11110, 32'd10,         32'd0,          32'hFFFF_FFFF,  EARLY_LAT);
    run_op("rem_by0",     5'b11101, 32'd10,         32'd0,          32'd10,         EARLY_LAT);
    run_op("div_ovf",     5'b11100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  EARLY_LAT);
    run_op("rem_ovf",     5'b11101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EARLY_LAT);
    run_op("remu_prev",   5'b11111, 32'd27,         32'd5,          32'd2,          DIV_LAT);

    // flush ten cycles into a divide: no DONE, result keeps 2
    @(negedge clk);
    bus.start = 1'b1; bus.select = 5'b11110; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
    end
    chk("flush_nodone", 32'(seen), 32'd0);
    chk("flush_res", bus.result, 32'd2);

    // start together with flush is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.select = 5'b11100; bus.data1 = 32'd9; bus.data2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("stflush_busy", 32'(bus.busy), 32'd0);

    // non-M op code is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.select = 5'b00000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("nonm_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("nonm_idle", 32'({bus.busy, bus.done}), 32'd0);

    // back-to-back: second START in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.select = 5'b11000; bus.data1 = 32'd3; bus.data2 = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    chk("b2b_first_res", bus.result, 32'd12);
    bus.start = 1'b1; bus.select = 5'b11110; bus.data1 = 32'd27; bus.data2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_nogap", 32'(bus.busy), 32'd1);
    wait_done(lat, bcnt);
    chk("b2b_second_res", bus.result, 32'd5);
    chk("b2b_second_lat", 32'(lat), 32'(DIV_LAT));

    // reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.select = 5'b11100; bus.data1 = 32'hFFFF_FFF9; bus.data2 = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_res", bus.result, 32'd0);
    run_op("post_rst",    5'b11111, 32'd27,         32'd5,          32'd2,          DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
